// File: rtl/alu_share_arbiter.sv
// Shares one integer ALU between two valid/ready requesters: one operation in flight at a time.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round robin.
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FUNC_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [FUNC_W-1:0] req1_func,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic [FUNC_W-1:0] alu_func,
  output logic [WIDTH-1:0]  alu_inp1,
  output logic [WIDTH-1:0]  alu_inp2,
  input  logic [WIDTH-1:0]  alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_data
);

  localparam logic [FUNC_W-1:0] FuncNop = FUNC_W'(3'b011);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q;
  logic   cur_id_q;
  logic   win1;
  logic   any_req;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic   last_grant_q;
`endif

  always_comb begin
    any_req = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    win1 = req1_valid & ~req0_valid;
`else
    // On a tie the requester that did not complete last goes first.
    win1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif
    // Gated by rst so no grant is advertised while reset is being applied.
    req0_ready = rst & (state_q == StIdle) & req0_valid & ~win1;
    req1_ready = rst & (state_q == StIdle) & win1;
  end

  // The ALU drive registers double as the op registers: loaded on accept, cleared after EXEC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cur_id_q     <= 1'b0;
      alu_func     <= FuncNop;
      alu_inp1     <= '0;
      alu_inp2     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q  <= StExec;
            cur_id_q <= win1;
            alu_func <= win1 ? req1_func : req0_func;
            alu_inp1 <= win1 ? req1_a : req0_a;
            alu_inp2 <= win1 ? req1_b : req0_b;
          end
        end
        StExec: begin
          state_q   <= StResp;
          rsp_data  <= alu_out;
          rsp_id    <= cur_id_q;
          rsp_valid <= 1'b1;
          alu_func  <= FuncNop;
          alu_inp1  <= '0;
          alu_inp2  <= '0;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q      <= StIdle;
            rsp_valid    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= cur_id_q;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Time-shares the single integer ALU between two requesters, for example the EX stage and a multicycle branch/address helper. Each requester offers an operation with a valid/ready handshake. The block picks one winner, drives the ALU from registered operands for one cycle, captures the result, and returns it with the winner's ID through a valid/ready response port. Only one operation is in flight at a time.

## Interface
- `WIDTH`, 32: operand and result width.
- `FUNC_W`, 3: ALU function code width. Codes are AND=000, OR=001, ADD=010, NOP=011, SUB=110, SLT=111.
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `req0_valid` / `req1_valid`  in  1  requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1  operation accepted this cycle.
- `req0_func` / `req1_func`  in  FUNC_W  ALU function code.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `alu_func`  out  FUNC_W  driven to the ALU `func` input.
- `alu_inp1`, `alu_inp2`  out  WIDTH  driven to the ALU operand inputs.
- `alu_out`  in  WIDTH  combinational result from the ALU.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  1  ID of the requester that owns the result (0 or 1).
- `rsp_data`  out  WIDTH  captured ALU result.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - `alu_func`=011 (NOP); `alu_inp1`=`alu_inp2`=0.
  - If any `reqN_valid` is high, choose a winner and assert only that requester's `reqN_ready`, combinationally in the same cycle.
  - On the clock edge, latch the winner's func/a/b into the op registers and the winner ID into `cur_id`. Go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC**
  - Drive `alu_func`/`alu_inp1`/`alu_inp2` from the op registers.
  - On the edge, capture `alu_out` into `rsp_data` and set `rsp_id`=`cur_id`. Go to RESP.
- **RESP**
  - `rsp_valid`=1; ALU outputs return to NOP/0.
  - When `rsp_valid` and `rsp_ready` are both high, update `last_grant`=`cur_id` and go to IDLE.
  - Otherwise hold `rsp_data` and `rsp_id` stable.
- **Arbitration**
  - Round robin: when both requesters are valid, the one not equal to `last_grant` wins.
  - When only one is valid, it wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- **Ready rules**
  - `reqN_ready` is high only in IDLE and only for the winner; it is 0 in EXEC and RESP.
  - A requester may change or drop its request while not granted; no request state is stored for the loser.
- **Data handling**
  - Func codes pass through unmodified. Unused codes 100/101 reach the ALU and yield 0.
  - SLT is an unsigned compare; the result is all-ones or zero.
- **Reset values:** state=IDLE, `req0_ready`=`req1_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `alu_func`=011, `alu_inp1`=`alu_inp2`=0, `last_grant`=1.
- **Reset mid-operation:** any in-flight operation or held response is discarded without being signalled.

## Timing
- Accept at cycle T (`ready`&`valid`) → ALU driven in T+1 → `rsp_valid` high from T+2.
- With `rsp_ready` held high, the response completes at T+2. The next accept can occur earliest at T+3.
- Peak throughput is one operation per 3 cycles.
- Backpressure: `rsp_valid` stays high for as long as `rsp_ready` is low. No request is accepted during that time.
- `rsp_ready` asserted while `rsp_valid`=0 has no effect.
- Both requests arriving in the same cycle: exactly one `ready` is asserted. The loser is served next, provided it stays valid.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; requester 0 always wins ties.
  - `last_grant` is not implemented.
  - Requester 1 can starve.
- `ALU_ARB_FIXED_PRIO_EN` undefined (default): round robin as described above.

## Test plan
- **Reset.** Hold `rst`=0 for 2 cycles with both requests valid → `req0_ready`=`req1_ready`=0, `rsp_valid`=0, `alu_func`=011. Release → `req0_ready`=1 in the first cycle.
- **Single ADD.** `req0`: func=010, a=5, b=7; `rsp_ready`=1 → `alu_func`=010 at T+1, `rsp_valid`=1 with `rsp_data`=12 and `rsp_id`=0 at T+2, IDLE at T+3.
- **Round robin.** Both requesters valid continuously: `req0` SUB 10−3, `req1` SLT 2<9 → grant order 0,1,0,1. Responses are 7 (ID 0) and 0xFFFFFFFF (ID 1), alternating.
- **Backpressure.** `req1` OR 0xF0|0x0F with `rsp_ready`=0 for 5 cycles → `rsp_valid` held, `rsp_data`=0xFF stable, `req0_ready`=0 throughout. `rsp_ready`=1 → IDLE the next cycle.
- **Reset mid-operation.** Pull `rst` low in EXEC → `rsp_valid` never rises. After release, the next tie is granted to requester 0.
- **Fixed priority (`ALU_ARB_FIXED_PRIO_EN` defined).** Both requesters valid for 12 cycles → 4 grants, all to requester 0; `req1_ready` stays 0.
